wave_gen_param: RTL and testbench

WAVE_GEN_PARAM -- requirements
Module: wave_gen_param

---
 rtl/wave_gen_pkg.sv | 25 ++
 rtl/wave_gen_shape.sv | 34 +++
 rtl/wave_gen_param.sv | 125 ++++++++++++
 tb/tb_wave_gen_param.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/wave_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wave_gen_pkg
//  Purpose  : Shared waveform-mode and state enums plus default widths.
//  Revision : 1.0  initial release
// ============================================================================
package wave_gen_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_PHASE_W = 16;

    typedef enum logic [1:0] {
        TRI = 2'd0,
        SAW = 2'd1,
        SQR = 2'd2,
        MID = 2'd3
    } wave_mode_e;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } fsm_state_e;

endpackage
`default_nettype wire

// File: rtl/wave_gen_shape.sv
`default_nettype none
// ============================================================================
//  Module   : wave_gen_shape
//  Purpose  : Combinational phase-to-sample shaper (tri/saw/square/midscale).
//  Revision : 1.0  initial release
// ============================================================================
module wave_gen_shape
    import wave_gen_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W:0]   phase_t,
    input  wave_mode_e        mode,
    output logic [DATA_W-1:0] shape
);

    logic              w_msb;
    logic [DATA_W-1:0] w_low;

    assign w_msb = phase_t[DATA_W];
    assign w_low = phase_t[DATA_W-1:0];

    always_comb begin
        shape = '0;
        unique case (mode)
            TRI: shape = w_msb ? ~w_low : w_low;
            SAW: shape = phase_t[DATA_W:1];
            SQR: shape = w_msb ? '0 : '1;
            MID: shape = {1'b1, {(DATA_W-1){1'b0}}};
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/wave_gen_param.sv
`default_nettype none
// ============================================================================
//  Module   : wave_gen_param
//  Purpose  : Phase-accumulator waveform generator with deferred mode switch.
//             Define WAVE_GEN_AMP_EN to add the amp port and output scaling.
//  Revision : 1.0  initial release
// ============================================================================
module wave_gen_param
    import wave_gen_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int PHASE_W = DEF_PHASE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [PHASE_W-1:0] step,
    input  logic [1:0]         mode_req,
    input  logic               mode_wr,
    input  logic               sync_clr,
`ifdef WAVE_GEN_AMP_EN
    input  logic [DATA_W-1:0]  amp,
`endif
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    output logic [1:0]         mode_cur
);

    logic [PHASE_W-1:0] phase_q, phase_d;
    fsm_state_e         state_q, state_d;
    wave_mode_e         mode_cur_q, mode_cur_d;
    wave_mode_e         pending_q, pending_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;

    logic [PHASE_W-1:0] w_sum;
    logic               w_carry;
    logic [DATA_W-1:0]  w_shape;
    logic [DATA_W-1:0]  w_sample;
    logic               w_pend_any;
    wave_mode_e         w_pend_val;
    logic               w_apply;

    assign {w_carry, w_sum} = {1'b0, phase_q} + {1'b0, step};

    wave_gen_shape #(
        .DATA_W (DATA_W)
    ) u_shape (
        .phase_t (phase_q[PHASE_W-1 -: DATA_W+1]),
        .mode    (mode_cur_q),
        .shape   (w_shape)
    );

`ifdef WAVE_GEN_AMP_EN
    logic [DATA_W:0]   w_amp1;
    logic [2*DATA_W:0] w_prod;

    assign w_amp1   = {1'b0, amp} + (DATA_W+1)'(1);
    assign w_prod   = (2*DATA_W+1)'(w_shape) * (2*DATA_W+1)'(w_amp1);
    assign w_sample = DATA_W'(w_prod >> DATA_W);
`else
    assign w_sample = w_shape;
`endif

    // A mode write in the same cycle as an apply event takes effect at once.
    assign w_pend_any = (state_q == PEND) || mode_wr;
    assign w_pend_val = mode_wr ? wave_mode_e'(mode_req) : pending_q;
    assign w_apply    = w_pend_any && (sync_clr || (in_valid && w_carry));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:  if (mode_wr && !w_apply) state_d = PEND;
            PEND: if (w_apply)             state_d = RUN;
        endcase
    end

    always_comb begin
        phase_d     = phase_q;
        mode_cur_d  = mode_cur_q;
        pending_d   = pending_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;

        if (mode_wr) begin
            pending_d = wave_mode_e'(mode_req);
        end
        if (w_apply) begin
            mode_cur_d = w_pend_val;
        end

        // Clear wins over a coincident tick: no sample, output held.
        if (sync_clr) begin
            phase_d = '0;
        end else if (in_valid) begin
            phase_d     = w_sum;
            out_data_d  = w_sample;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q     <= '0;
            state_q     <= RUN;
            mode_cur_q  <= TRI;
            pending_q   <= TRI;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            state_q     <= state_d;
            mode_cur_q  <= mode_cur_d;
            pending_q   <= pending_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign mode_cur  = mode_cur_q;

endmodule
`default_nettype wire

// File: tb/tb_wave_gen_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wave_gen_param
//  Purpose  : Scoreboard bench for wave_gen_param (DATA_W=8, PHASE_W=9).
//  Revision : 1.0  initial release
// ============================================================================
module tb_wave_gen_param;

    localparam int DW = 8;
    localparam int PW = 9;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          in_valid = 1'b0;
    logic          mode_wr  = 1'b0;
    logic          sync_clr = 1'b0;
    logic [PW-1:0] step     = '0;
    logic [1:0]    mode_req = '0;
`ifdef WAVE_GEN_AMP_EN
    logic [DW-1:0] amp      = '1;
`endif
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic [1:0]    mode_cur;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] sb[$];
    logic [DW-1:0] exp_q;

    wave_gen_param #(
        .DATA_W  (DW),
        .PHASE_W (PW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .step      (step),
        .mode_req  (mode_req),
        .mode_wr   (mode_wr),
        .sync_clr  (sync_clr),
`ifdef WAVE_GEN_AMP_EN
        .amp       (amp),
`endif
        .out_data  (out_data),
        .out_valid (out_valid),
        .mode_cur  (mode_cur)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every out_valid pulse consumes one expected sample.
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_sample: got %0d expected none", out_data);
            end else begin
                exp_q = sb.pop_front();
                check("sample", {24'd0, out_data}, {24'd0, exp_q});
            end
        end
    end

    function automatic logic [DW-1:0] tri9(input int p);
        return (p < 256) ? DW'(p) : DW'(511 - p);
    endfunction

    task automatic tick(input logic [PW-1:0] st, input logic [DW-1:0] exp);
        in_valid = 1'b1;
        step     = st;
        sb.push_back(exp);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wr_mode(input logic [1:0] m, input logic clr);
        mode_wr  = 1'b1;
        mode_req = m;
        sync_clr = clr;
        @(negedge clk);
        mode_wr  = 1'b0;
        sync_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_out_data", {24'd0, out_data}, 0);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_mode_cur", {30'd0, mode_cur}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Triangle, full period then wrap.
        for (int i = 0; i < 512; i++) tick(1, tri9(i));
        tick(1, 8'd0);

        // Sawtooth selected by write coincident with clear.
        wr_mode(2'd1, 1'b1);
        check("clr_wr_mode", {30'd0, mode_cur}, 1);
        for (int i = 0; i < 256; i++) tick(2, DW'(i));
        tick(2, 8'd0);

        // Deferred switch to square, with an overwritten pending write.
        wr_mode(2'd0, 1'b1);
        check("clr_tri_mode", {30'd0, mode_cur}, 0);
        for (int i = 0; i < 100; i++) tick(1, tri9(i));
        wr_mode(2'd3, 1'b0);
        check("pend_hold_mode", {30'd0, mode_cur}, 0);
        for (int i = 100; i < 150; i++) tick(1, tri9(i));
        wr_mode(2'd2, 1'b0);
        for (int i = 150; i < 512; i++) tick(1, tri9(i));
        check("deferred_mode", {30'd0, mode_cur}, 2);
        tick(1, 8'd255);

        // Clear together with a tick at phase 300.
        wr_mode(2'd0, 1'b1);
        tick(100, 8'd0);
        tick(100, 8'd100);
        tick(100, 8'd200);
        in_valid = 1'b1;
        step     = 100;
        sync_clr = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        sync_clr = 1'b0;
        check("clr_out_valid", {31'd0, out_valid}, 0);
        check("clr_out_data_hold", {24'd0, out_data}, 200);
        tick(1, 8'd0);

        // Zero step: constant samples.
        tick(0, 8'd1);
        tick(0, 8'd1);
        tick(0, 8'd1);

        // Mode write coincident with a carry-out tick.
        in_valid = 1'b1;
        step     = 511;
        mode_wr  = 1'b1;
        mode_req = 2'd3;
        sb.push_back(8'd1);
        @(negedge clk);
        in_valid = 1'b0;
        mode_wr  = 1'b0;
        check("carry_wr_mode", {30'd0, mode_cur}, 3);
        tick(0, 8'd128);

        // Asynchronous reset while a mode is pending.
        wr_mode(2'd2, 1'b0);
        check("pend_before_rst", {30'd0, mode_cur}, 3);
        in_valid = 1'b1;
        step     = 1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        sb.delete();
        #1;
        check("async_rst_data", {24'd0, out_data}, 0);
        check("async_rst_valid", {31'd0, out_valid}, 0);
        check("async_rst_mode", {30'd0, mode_cur}, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 512; i++) tick(1, tri9(i));
        tick(1, 8'd0);
        check("rst_drop_pending", {30'd0, mode_cur}, 0);

        @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
